// File: rtl/ups_dac_arb_pkg.sv
// Shared definitions for the DAC arbiter slice.
//   UPS_DAC_W       : default DAC word width
//   ups_arb_state_t : arbiter FSM states (IDLE accepts, GAP enforces frame spacing)
//   ups_idw()       : requester index width, never below 1 bit
package ups_pkg;

  localparam int UPS_DAC_W = 16;

  typedef enum logic {IDLE, GAP} ups_arb_state_t;

  function automatic int ups_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ups_dac_arb_if.sv
// Requester/DAC bundle of the arbiter.
//   rr_en     : 1 = round-robin, 0 = fixed priority
//   req_valid : per-requester valid
//   req_data  : per-requester word
//   req_ready : one-hot accept
//   dac       : issued word, held until the next issue
//   dac_dv    : one-cycle issue strobe
//   gnt_id    : index of the last accepted requester
//   busy      : high while frame spacing is being enforced
// master = requester/consumer side, slave = arbiter side.
interface ups_dac_arb_if
  import ups_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DAC_W = UPS_DAC_W
);
  localparam int IDW = ups_idw(NREQ);

  logic                        rr_en;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][DAC_W-1:0]  req_data;
  logic [NREQ-1:0]             req_ready;
  logic [DAC_W-1:0]            dac;
  logic                        dac_dv;
  logic [IDW-1:0]              gnt_id;
  logic                        busy;

  modport master (
    output rr_en, req_valid, req_data,
    input  req_ready, dac, dac_dv, gnt_id, busy
  );

  modport slave (
    input  rr_en, req_valid, req_data,
    output req_ready, dac, dac_dv, gnt_id, busy
  );
endinterface

// File: rtl/ups_dac_arb_pick.sv
// Combinational winner selection.
//   req   : request vector
//   base  : round-robin search start (ignored when rr_en=0)
//   rr_en : 1 = search from base with wrap, 0 = lowest index wins
//   gnt   : one-hot winner
//   idx   : winner index
//   any   : at least one request present
module ups_arb_pick
  import ups_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = ups_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  base,
  input  logic            rr_en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int unsigned       start;
  int unsigned       pos;
  logic              found;

  // Rotating the doubled vector right by the start index puts the search
  // origin at bit 0, so a plain lowest-bit encoder yields the wrapped winner.
  always_comb begin
    start = rr_en ? int'(base) : 0;
    dbl   = {req, req} >> start;
    rot   = dbl[NREQ-1:0];
    any   = |req;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = start + i;
        if (pos >= NREQ) pos = pos - NREQ;
        idx   = IDW'(pos);
      end
    end
    gnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt[i] = any && (IDW'(i) == idx);
    end
  end

endmodule

// File: rtl/ups_dac_arb.sv
// Arbitrates the single DAC channel between NREQ sources and issues one word
// per frame to ups_da as a one-cycle dac_dv strobe, spaced at least
// FRAME_CYC cycles apart.
//   clk   : fabric clock
//   rst_n : asynchronous active-low reset
//   bus   : requester/DAC bundle (slave side)
module ups_dac_arb
  import ups_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int DAC_W     = UPS_DAC_W,
  parameter int FRAME_CYC = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  ups_dac_arb_if.slave  bus
);

  localparam int IDW = ups_idw(NREQ);
  localparam int CW  = $clog2(FRAME_CYC);

  ups_arb_state_t   state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [DAC_W-1:0] dac_q, dac_d;
  logic             dv_q, dv_d;
  logic [IDW-1:0]   gid_q, gid_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   idx;
  logic             any;

  ups_arb_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (bus.req_valid),
    .base  (ptr_q),
    .rr_en (bus.rr_en),
    .gnt   (gnt),
    .idx   (idx),
    .any   (any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    dac_d   = dac_q;
    dv_d    = 1'b0;
    gid_d   = gid_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GAP;
          cnt_d   = CW'(FRAME_CYC - 1);
          dac_d   = bus.req_data[idx];
          dv_d    = 1'b1;
          gid_d   = idx;
          if (bus.rr_en)
            ptr_d = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
      end
      GAP: begin
        // Counter is always >=1 here, so it stops at 0 without wrapping.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      dac_q   <= '0;
      dv_q    <= 1'b0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      dac_q   <= dac_d;
      dv_q    <= dv_d;
      gid_q   <= gid_d;
    end
  end

  // Reset resets state to IDLE, which alone would let ready through; the
  // rst_n term keeps ready low while reset is held.
  assign bus.req_ready = gnt & {NREQ{(state_q == IDLE) && rst_n}};
  assign bus.dac       = dac_q;
  assign bus.dac_dv    = dv_q;
  assign bus.gnt_id    = gid_q;
  assign bus.busy      = (state_q == GAP);

endmodule

// File: tb/tb_ups_dac_arb.sv
module tb_ups_dac_arb;
  import ups_pkg::*;

  localparam int NREQ      = 3;
  localparam int DAC_W     = 16;
  localparam int FRAME_CYC = 40;

  localparam logic [15:0] DA = 16'hAAAA;
  localparam logic [15:0] DB = 16'hBBBB;
  localparam logic [15:0] DC = 16'hCCCC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ups_dac_arb_if #(.NREQ(NREQ), .DAC_W(DAC_W)) bus ();

  ups_dac_arb #(.NREQ(NREQ), .DAC_W(DAC_W), .FRAME_CYC(FRAME_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Ticks until the next dac_dv strobe; n = number of edges waited.
  task automatic wait_dv(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.dac_dv && n < 200);
    chk("dv_timeout", {31'd0, bus.dac_dv}, 32'd1);
  endtask

  int n;
  int nb;
  int seq [5] = '{0, 1, 2, 0, 1};

  initial begin
    bus.rr_en     = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '{DC, DB, DA};

    // 1: reset with all requesting
    bus.req_valid = 3'b111;
    rst_n = 1'b0;
    tick();
    chk("rst_ready", {29'd0, bus.req_ready}, 32'd0);
    chk("rst_dv",    {31'd0, bus.dac_dv},    32'd0);
    chk("rst_dac",   {16'd0, bus.dac},       32'd0);
    chk("rst_busy",  {31'd0, bus.busy},      32'd0);
    chk("rst_gnt",   {30'd0, bus.gnt_id},    32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {29'd0, bus.req_ready}, 32'd1);
    tick();
    chk("first_dv",  {31'd0, bus.dac_dv},    32'd1);
    chk("first_dac", {16'd0, bus.dac},       {16'd0, DA});

    // 2: single source, latency, busy length, next accept
    bus.req_valid = 3'b000;
    do_reset();
    bus.req_data[0] = 16'h1234;
    bus.req_valid   = 3'b001;
    #1;
    chk("s_ready", {29'd0, bus.req_ready}, 32'd1);
    tick();
    chk("s_dv",    {31'd0, bus.dac_dv},    32'd1);
    chk("s_dac",   {16'd0, bus.dac},       32'h1234);
    chk("s_gapready", {29'd0, bus.req_ready}, 32'd0);
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      tick();
      if (nb == 1) chk("s_dv_one", {31'd0, bus.dac_dv}, 32'd0);
    end
    chk("s_busylen", nb, 39);
    chk("s_ready2", {29'd0, bus.req_ready}, 32'd1);
    tick();
    chk("s_dv2", {31'd0, bus.dac_dv}, 32'd1);
    // no request while idle: dac holds
    bus.req_valid = 3'b000;
    n = 0;
    while (bus.busy && n < 100) begin n++; tick(); end
    tick(); tick(); tick();
    chk("hold_dac", {16'd0, bus.dac}, 32'h1234);
    chk("hold_dv",  {31'd0, bus.dac_dv}, 32'd0);
    chk("hold_busy", {31'd0, bus.busy}, 32'd0);
    bus.req_data[0] = DA;

    // 3: fixed priority starves 1 and 2
    do_reset();
    bus.rr_en = 1'b0;
    bus.req_valid = 3'b111;
    tick();
    chk("fp_g0", {30'd0, bus.gnt_id}, 32'd0);
    chk("fp_d0", {16'd0, bus.dac}, {16'd0, DA});
    for (int k = 1; k < 3; k++) begin
      wait_dv(n);
      chk("fp_gap", n, FRAME_CYC);
      chk("fp_g",   {30'd0, bus.gnt_id}, 32'd0);
      chk("fp_d",   {16'd0, bus.dac}, {16'd0, DA});
    end

    // 4: round-robin order and spacing
    bus.req_valid = 3'b000;
    do_reset();
    bus.rr_en = 1'b1;
    bus.req_valid = 3'b111;
    tick();
    chk("rr_g0", {30'd0, bus.gnt_id}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      wait_dv(n);
      chk("rr_gap", n, FRAME_CYC);
      chk("rr_g", {30'd0, bus.gnt_id}, seq[k]);
    end
    chk("rr_dac", {16'd0, bus.dac}, {16'd0, DB});

    // 5: rr_en toggled during GAP
    bus.req_valid = 3'b000;
    do_reset();
    bus.rr_en = 1'b1;
    bus.req_valid = 3'b111;
    tick();
    wait_dv(n);
    chk("tg_g1", {30'd0, bus.gnt_id}, 32'd1);
    repeat (5) tick();
    bus.rr_en = 1'b0;
    wait_dv(n);
    chk("tg_fix", {30'd0, bus.gnt_id}, 32'd0);
    chk("tg_fixd", {16'd0, bus.dac}, {16'd0, DA});
    repeat (5) tick();
    bus.rr_en = 1'b1;
    wait_dv(n);
    chk("tg_rr2", {30'd0, bus.gnt_id}, 32'd2);
    chk("tg_rr2d", {16'd0, bus.dac}, {16'd0, DC});

    // 6: async reset mid-GAP at counter=20
    bus.req_valid = 3'b000;
    do_reset();
    bus.rr_en = 1'b0;
    bus.req_valid = 3'b001;
    tick();
    bus.req_valid = 3'b000;
    repeat (19) tick();
    chk("ar_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, bus.busy}, 32'd0);
    chk("ar_dac",  {16'd0, bus.dac},  32'd0);
    chk("ar_gnt",  {30'd0, bus.gnt_id}, 32'd0);
    bus.req_valid = 3'b100;
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar_ready", {29'd0, bus.req_ready}, 32'd4);
    tick();
    chk("ar_dv",  {31'd0, bus.dac_dv}, 32'd1);
    chk("ar_g2",  {30'd0, bus.gnt_id}, 32'd2);
    chk("ar_d2",  {16'd0, bus.dac}, {16'd0, DC});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
